// File: rtl/z80_bus_responder.sv
// z80_bus_responder: slave end of the tv80s/Z80 bus. Serves memory cycles from an
// internal byte RAM, I/O cycles from a 16-entry register file, answers interrupt
// acknowledge with a fixed vector and stretches cycles through wait_n.
// Optional feature macro: Z80RESP_WRPROT_EN (discard memory writes below ROM_TOP).
module z80_bus_responder #(
   parameter int unsigned ADDR_W   = 16,
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned IO_WAIT  = 1,
   parameter logic [15:0] ROM_TOP  = 16'h0000,
   parameter logic [7:0]  INTA_VEC = 8'hFF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [15:0]  A,
   input  logic [7:0]   dout,
   input  logic         m1_n,
   input  logic         mreq_n,
   input  logic         iorq_n,
   input  logic         rd_n,
   input  logic         wr_n,
   input  logic         rfsh_n,
   output logic [7:0]   di,
   output logic         wait_n,
   output logic [127:0] io_port
);

   localparam logic [2:0] MemWaitC = 3'(MEM_WAIT);
   localparam logic [2:0] IoWaitC  = 3'(IO_WAIT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_HOLD
   } state_e;

   typedef enum logic [2:0] {
      C_MRD,
      C_MWR,
      C_IORD,
      C_IOWR,
      C_INTA
   } cyc_e;

   state_e            state_q;
   cyc_e              cyc_q;
   logic [2:0]        cnt_q;
   logic [7:0]        di_q;
   logic              wait_n_q;
   logic [7:0]        io_q [16];
   logic [7:0]        mem_q [1 << ADDR_W];

   logic              det_valid;
   cyc_e              det_cyc;
   logic [2:0]        det_wait;
   logic              wr_allow;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_idx;

   assign mem_idx = A[ADDR_W-1:0];
   assign di      = di_q;
   assign wait_n  = wait_n_q;

   // Classify the bus cycle; INTA beats I/O, I/O beats memory, refresh is ignored.
   always_comb begin
      det_valid = 1'b1;
      det_cyc   = C_MRD;
      det_wait  = MemWaitC;
      if (!iorq_n && !m1_n) begin
         det_cyc  = C_INTA;
         det_wait = IoWaitC;
      end else if (!iorq_n && !rd_n && m1_n) begin
         det_cyc  = C_IORD;
         det_wait = IoWaitC;
      end else if (!iorq_n && !wr_n) begin
         det_cyc  = C_IOWR;
         det_wait = IoWaitC;
      end else if (!mreq_n && !rd_n && rfsh_n) begin
         det_cyc  = C_MRD;
      end else if (!mreq_n && !wr_n && rfsh_n) begin
         det_cyc  = C_MWR;
      end else begin
         det_valid = 1'b0;
      end
   end

   // Write-protect window for the low (ROM) part of the address space.
   always_comb begin
`ifdef Z80RESP_WRPROT_EN
      wr_allow = (A >= ROM_TOP);
`else
      // Protection compiled out: every address is writable, ROM_TOP has no effect.
      wr_allow = (A >= ROM_TOP) | 1'b1;
`endif
      mem_we = reset_n && (state_q == S_ACCESS) && (cyc_q == C_MWR) && wr_allow;
   end

   // Bus-cycle FSM with registered di, wait_n and I/O register file.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cyc_q    <= C_MRD;
         cnt_q    <= '0;
         di_q     <= '0;
         wait_n_q <= 1'b1;
         for (int unsigned i = 0; i < 16; i++) begin
            io_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (det_valid) begin
                  cyc_q <= det_cyc;
                  cnt_q <= det_wait;
                  if (det_wait != 3'd0) begin
                     state_q  <= S_WAIT;
                     wait_n_q <= 1'b0;
                  end else begin
                     state_q  <= S_ACCESS;
                  end
               end
            end
            S_WAIT: begin
               if (mreq_n && iorq_n) begin
                  state_q  <= S_IDLE;
                  wait_n_q <= 1'b1;
               end else if (cnt_q == 3'd1) begin
                  state_q  <= S_ACCESS;
                  wait_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            S_ACCESS: begin
               case (cyc_q)
                  C_MRD:   di_q <= mem_q[mem_idx];
                  C_IORD:  di_q <= io_q[A[3:0]];
                  C_INTA:  di_q <= INTA_VEC;
                  C_IOWR:  io_q[A[3:0]] <= dout;
                  default: ;
               endcase
               state_q <= S_HOLD;
            end
            S_HOLD: begin
               if (mreq_n && iorq_n) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // RAM write port; RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_idx] <= dout;
      end
   end

   // Flatten the I/O register file, port 0 in the low byte.
   always_comb begin
      io_port = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         io_port[i*8 +: 8] = io_q[i];
      end
   end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: two instances share the bus, one with
// memory/I-O waits (2/1) and one with none (0/0), both with INTA_VEC=E7 and
// ROM_TOP=1000.
module tb_z80_bus_responder;

   localparam int K_MRD  = 0;
   localparam int K_MWR  = 1;
   localparam int K_IORD = 2;
   localparam int K_IOWR = 3;
   localparam int K_INTA = 4;
   localparam int K_RFSH = 5;

   logic         clk;
   logic         reset_n;
   logic [15:0]  A;
   logic [7:0]   dout;
   logic         m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
   logic [7:0]   di_d, di_f;
   logic         wn_d, wn_f;
   logic [127:0] io_d, io_f;

   int checks = 0;
   int errors = 0;

   logic [7:0] dd [8];
   logic [7:0] df [8];
   int         lows_d, lows_f;

   z80_bus_responder #(
      .ADDR_W(16), .MEM_WAIT(2), .IO_WAIT(1), .ROM_TOP(16'h1000), .INTA_VEC(8'hE7)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .A(A), .dout(dout),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
      .di(di_d), .wait_n(wn_d), .io_port(io_d)
   );

   z80_bus_responder #(
      .ADDR_W(16), .MEM_WAIT(0), .IO_WAIT(0), .ROM_TOP(16'h1000), .INTA_VEC(8'hE7)
   ) u_fast (
      .clk(clk), .reset_n(reset_n), .A(A), .dout(dout),
      .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
      .di(di_f), .wait_n(wn_f), .io_port(io_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_bus();
      m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
      rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
   endtask

   // One bus cycle: called at a negedge, strobes held for 8 clocks, then released.
   task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data);
      A = addr;
      dout = data;
      case (kind)
         K_MRD:  begin mreq_n = 1'b0; rd_n = 1'b0; end
         K_MWR:  begin mreq_n = 1'b0; wr_n = 1'b0; end
         K_IORD: begin iorq_n = 1'b0; rd_n = 1'b0; end
         K_IOWR: begin iorq_n = 1'b0; wr_n = 1'b0; end
         K_INTA: begin iorq_n = 1'b0; m1_n = 1'b0; end
         default: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
      endcase
      lows_d = 0;
      lows_f = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         dd[i] = di_d;
         df[i] = di_f;
         if (wn_d === 1'b0) lows_d++;
         if (wn_f === 1'b0) lows_f++;
      end
      idle_bus();
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle_bus();
      A = 16'h0000;
      dout = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (di_d !== 8'h00) begin errors++; $display("FAIL reset_di_dut: got %h want 00", di_d); end
      checks++; if (di_f !== 8'h00) begin errors++; $display("FAIL reset_di_fast: got %h want 00", di_f); end
      checks++; if (wn_d !== 1'b1) begin errors++; $display("FAIL reset_wait_dut: got %b want 1", wn_d); end
      checks++; if (wn_f !== 1'b1) begin errors++; $display("FAIL reset_wait_fast: got %b want 1", wn_f); end
      checks++; if (io_d !== 128'h0) begin errors++; $display("FAIL reset_io_dut: got %h want 0", io_d); end
      checks++; if (io_f !== 128'h0) begin errors++; $display("FAIL reset_io_fast: got %h want 0", io_f); end
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_mem_nowait();
      bus_cycle(K_MWR, 16'h1234, 8'h5A);
      checks++; if (lows_f != 0) begin errors++; $display("FAIL mwr_lows_fast: got %0d want 0", lows_f); end
      bus_cycle(K_MRD, 16'h1234, 8'h00);
      checks++; if (lows_f != 0) begin errors++; $display("FAIL mrd_lows_fast: got %0d want 0", lows_f); end
      checks++; if (df[0] !== 8'h00) begin errors++; $display("FAIL mrd_di_early_fast: got %h want 00", df[0]); end
      checks++; if (df[1] !== 8'h5A) begin errors++; $display("FAIL mrd_di_fast: got %h want 5a", df[1]); end
      checks++; if (lows_d != 2) begin errors++; $display("FAIL mrd_lows_dut: got %0d want 2", lows_d); end
      checks++; if (dd[2] !== 8'h00) begin errors++; $display("FAIL mrd_di_early_dut: got %h want 00", dd[2]); end
      checks++; if (dd[3] !== 8'h5A) begin errors++; $display("FAIL mrd_di_dut: got %h want 5a", dd[3]); end
   endtask

   task automatic test_mem_wait();
      bus_cycle(K_MWR, 16'h4000, 8'hC3);
      checks++; if (lows_d != 2) begin errors++; $display("FAIL mwr_lows_dut: got %0d want 2", lows_d); end
      bus_cycle(K_MRD, 16'h4000, 8'h00);
      checks++; if (di_d !== 8'hC3) begin errors++; $display("FAIL mwr_readback_dut: got %h want c3", di_d); end
      checks++; if (di_f !== 8'hC3) begin errors++; $display("FAIL mwr_readback_fast: got %h want c3", di_f); end
   endtask

   task automatic test_io_alias();
      bus_cycle(K_IOWR, 16'h0025, 8'h77);
      checks++; if (lows_d != 1) begin errors++; $display("FAIL iowr_lows_dut: got %0d want 1", lows_d); end
      checks++; if (lows_f != 0) begin errors++; $display("FAIL iowr_lows_fast: got %0d want 0", lows_f); end
      checks++; if (io_d !== (128'h77 << 40)) begin errors++; $display("FAIL iowr_ports_dut: got %h", io_d); end
      checks++; if (io_f !== (128'h77 << 40)) begin errors++; $display("FAIL iowr_ports_fast: got %h", io_f); end
      bus_cycle(K_IORD, 16'h0005, 8'h00);
      checks++; if (di_d !== 8'h77) begin errors++; $display("FAIL iord_alias_dut: got %h want 77", di_d); end
      checks++; if (di_f !== 8'h77) begin errors++; $display("FAIL iord_alias_fast: got %h want 77", di_f); end
   endtask

   task automatic test_inta_refresh();
      bus_cycle(K_INTA, 16'h1234, 8'h00);
      checks++; if (di_d !== 8'hE7) begin errors++; $display("FAIL inta_di_dut: got %h want e7", di_d); end
      checks++; if (di_f !== 8'hE7) begin errors++; $display("FAIL inta_di_fast: got %h want e7", di_f); end
      checks++; if (io_d !== (128'h77 << 40)) begin errors++; $display("FAIL inta_ports_dut: got %h", io_d); end
      bus_cycle(K_RFSH, 16'h007F, 8'h00);
      checks++; if (di_d !== 8'hE7) begin errors++; $display("FAIL rfsh_di_dut: got %h want e7", di_d); end
      checks++; if (di_f !== 8'hE7) begin errors++; $display("FAIL rfsh_di_fast: got %h want e7", di_f); end
      checks++; if (lows_d != 0) begin errors++; $display("FAIL rfsh_lows_dut: got %0d want 0", lows_d); end
      bus_cycle(K_MRD, 16'h1234, 8'h00);
      checks++; if (di_d !== 8'h5A) begin errors++; $display("FAIL inta_ram_dut: got %h want 5a", di_d); end
   endtask

   task automatic test_wrprot();
      bus_cycle(K_MWR, 16'h0FFF, 8'hAA);
      bus_cycle(K_MWR, 16'h1000, 8'hAA);
      bus_cycle(K_MRD, 16'h1000, 8'h00);
      checks++; if (di_d !== 8'hAA) begin errors++; $display("FAIL wp_above_dut: got %h want aa", di_d); end
      checks++; if (di_f !== 8'hAA) begin errors++; $display("FAIL wp_above_fast: got %h want aa", di_f); end
      bus_cycle(K_MRD, 16'h0FFF, 8'h00);
`ifdef Z80RESP_WRPROT_EN
      checks++; if (di_d === 8'hAA) begin errors++; $display("FAIL wp_below_dut: got %h want not aa", di_d); end
`else
      checks++; if (di_d !== 8'hAA) begin errors++; $display("FAIL wp_below_dut: got %h want aa", di_d); end
`endif
   endtask

   task automatic test_reset_in_wait();
      bus_cycle(K_MWR, 16'h2000, 8'h11);
      A = 16'h2000;
      dout = 8'h99;
      mreq_n = 1'b0;
      wr_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (wn_d !== 1'b0) begin errors++; $display("FAIL rstw_wait_low: got %b want 0", wn_d); end
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (wn_d !== 1'b1) begin errors++; $display("FAIL rstw_wait_high: got %b want 1", wn_d); end
      idle_bus();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_cycle(K_MRD, 16'h2000, 8'h00);
      checks++; if (lows_d != 2) begin errors++; $display("FAIL rstw_idle_dut: got %0d lows want 2", lows_d); end
      checks++; if (di_d !== 8'h11) begin errors++; $display("FAIL rstw_ram_dut: got %h want 11", di_d); end
      checks++; if (di_f !== 8'h11) begin errors++; $display("FAIL rstw_ram_fast: got %h want 11", di_f); end
   endtask

   task automatic test_back_to_back();
      bus_cycle(K_IOWR, 16'h000F, 8'h3C);
      bus_cycle(K_IOWR, 16'h001E, 8'h5D);
      checks++; if (io_d !== {8'h3C, 8'h5D, 112'h0}) begin errors++; $display("FAIL b2b_ports_dut: got %h", io_d); end
      checks++; if (io_f !== {8'h3C, 8'h5D, 112'h0}) begin errors++; $display("FAIL b2b_ports_fast: got %h", io_f); end
      bus_cycle(K_IORD, 16'h00EF, 8'h00);
      checks++; if (di_d !== 8'h3C) begin errors++; $display("FAIL b2b_read_dut: got %h want 3c", di_d); end
   endtask

   initial begin
      test_reset();
      test_mem_nowait();
      test_mem_wait();
      test_io_alias();
      test_inta_refresh();
      test_wrprot();
      test_reset_in_wait();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
